// File: rtl/mux_pkg.sv
// Shared types for the 2:1 source arbiter: source identifiers and output-register states.
package mux_pkg;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} arb_st_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the source not served last,
// and an active lock pins the grant to the locked source.
module rr_arb2
  import mux_pkg::*;
(
  input  logic [1:0] req,
  input  src_e       last_src,
  input  logic       lock,
  input  src_e       lock_src,
  output src_e       gnt,
  output logic       gnt_vld
);

  always_comb begin
    gnt     = SRC_A;
    gnt_vld = 1'b0;
    if (lock) begin
      // While locked the other source is ignored even if the locked one is idle.
      gnt     = lock_src;
      gnt_vld = (lock_src == SRC_B) ? req[1] : req[0];
    end else begin
      unique case (req)
        2'b01: begin
          gnt     = SRC_A;
          gnt_vld = 1'b1;
        end
        2'b10: begin
          gnt     = SRC_B;
          gnt_vld = 1'b1;
        end
        2'b11: begin
          gnt     = other_src(last_src);
          gnt_vld = 1'b1;
        end
        default: begin
          gnt     = SRC_A;
          gnt_vld = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mux_src_arbiter.sv
// Arbitrates two valid/ready sources into one registered beat and drives the downstream mux select.
// Optional packet locking via a_last/b_last/out_last when MUX_ARB_LOCK_EN is defined.
module mux_src_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic              a_last,
  input  logic              b_last,
  output logic              out_last,
`endif
  output logic              sel
);

  arb_st_e           state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  src_e              sel_q, sel_d;
  src_e              rr_q, rr_d;
  src_e              gnt;
  logic              gnt_vld;
  logic              can_load;
  logic              accept;
  logic              lock_active;

`ifdef MUX_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;
  assign lock_active = lock_q;
`else
  assign lock_active = 1'b0;
`endif

  // The locked source is always the one served last, so rr_q doubles as the lock owner.
  rr_arb2 u_rr_arb2 (
    .req      ({b_valid, a_valid}),
    .last_src (rr_q),
    .lock     (lock_active),
    .lock_src (rr_q),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld)
  );

  assign can_load = (state_q == ST_EMPTY) || out_ready;
  assign accept   = can_load && gnt_vld;
  assign a_ready  = accept && (gnt == SRC_A);
  assign b_ready  = accept && (gnt == SRC_B);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
`ifdef MUX_ARB_LOCK_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    if (accept) begin
      state_d = ST_FULL;
      data_d  = (gnt == SRC_B) ? b_data : a_data;
      sel_d   = gnt;
      rr_d    = gnt;
`ifdef MUX_ARB_LOCK_EN
      last_d  = (gnt == SRC_B) ? b_last : a_last;
      lock_d  = !last_d;
`endif
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // rr_q resets to B so the first tie after reset goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= SRC_A;
      rr_q    <= SRC_B;
`ifdef MUX_ARB_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
`ifdef MUX_ARB_LOCK_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;
`ifdef MUX_ARB_LOCK_EN
  assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Self-checking bench for mux_src_arbiter: directed scenarios with literal expectations followed by
// randomized traffic checked every cycle against a beat-level reference model (MUX_ARB_LOCK_EN aware).
module tb_mux_src_arbiter;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              aValid, bValid, outReady;
  logic [DATA_W-1:0] aData, bData;
  logic              aReady, bReady, outValid, sel;
  logic [DATA_W-1:0] outData;
`ifdef MUX_ARB_LOCK_EN
  logic              aLast, bLast, outLast;
`endif

  int total = 0;
  int bad   = 0;

  mux_src_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (aValid),
    .a_ready   (aReady),
    .a_data    (aData),
    .b_valid   (bValid),
    .b_ready   (bReady),
    .b_data    (bData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
`ifdef MUX_ARB_LOCK_EN
    .a_last    (aLast),
    .b_last    (bLast),
    .out_last  (outLast),
`endif
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the beat currently held downstream, who was served last, and whether a packet is open.
  logic              mValid;
  logic [DATA_W-1:0] mData;
  logic              mSel;
  logic              mLastSrc;
  logic              mLocked;
  logic              expA, expB;
  logic              grantValid, grantSrc;
`ifdef MUX_ARB_LOCK_EN
  logic              mLock, mOutLast;
  assign mLocked = mLock;
`else
  assign mLocked = 1'b0;
`endif

  // Which source deserves the output slot: {wants, source}.
  function automatic logic [1:0] pickSource(input logic av, input logic bv,
                                            input logic lastSrc, input logic locked);
    if (locked)   return {(lastSrc ? bv : av), lastSrc};
    if (av && bv) return {1'b1, ~lastSrc};
    if (av)       return 2'b10;
    if (bv)       return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    {grantValid, grantSrc} = pickSource(aValid, bValid, mLastSrc, mLocked);
    expA = 1'b0;
    expB = 1'b0;
    if (grantValid && (!mValid || outReady)) begin
      expA = (grantSrc == 1'b0);
      expB = (grantSrc == 1'b1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid   <= 1'b0;
      mData    <= '0;
      mSel     <= 1'b0;
      mLastSrc <= 1'b1;
`ifdef MUX_ARB_LOCK_EN
      mLock    <= 1'b0;
      mOutLast <= 1'b0;
`endif
    end else if (expA || expB) begin
      mValid   <= 1'b1;
      mData    <= expB ? bData : aData;
      mSel     <= expB;
      mLastSrc <= expB;
`ifdef MUX_ARB_LOCK_EN
      mLock    <= expB ? !bLast : !aLast;
      mOutLast <= expB ? bLast : aLast;
`endif
    end else if (mValid && outReady) begin
      mValid   <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, mid-period, the DUT must agree with the model.
  always @(negedge clk) begin
    checkOutput("model_out_valid", 32'(outValid), 32'(mValid));
    checkOutput("model_out_data",  32'(outData),  32'(mData));
    checkOutput("model_sel",       32'(sel),      32'(mSel));
    checkOutput("model_a_ready",   32'(aReady),   32'(expA));
    checkOutput("model_b_ready",   32'(bReady),   32'(expB));
    checkOutput("model_not_both",  32'(aReady && bReady), 32'd0);
`ifdef MUX_ARB_LOCK_EN
    checkOutput("model_out_last",  32'(outLast),  32'(mOutLast));
`endif
  end

  task automatic applyStimulus(input logic av, input logic [DATA_W-1:0] ad,
                               input logic bv, input logic [DATA_W-1:0] bd,
                               input logic ordy);
    aValid   = av;
    aData    = ad;
    bValid   = bv;
    bData    = bd;
    outReady = ordy;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  logic accA, accB;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
`ifdef MUX_ARB_LOCK_EN
    aLast = 1'b1;
    bLast = 1'b1;
`endif
    #12;
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_data",  32'(outData),  32'd0);
    checkOutput("reset_sel",       32'(sel),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    // Tie for four cycles: A first, then strict alternation with no bubbles.
    applyStimulus(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("tie_out_valid", 32'(outValid), 32'd1);
      checkOutput("tie_sel",       32'(sel),      32'(i % 2));
      checkOutput("tie_out_data",  32'(outData),  (i % 2 == 0) ? 32'hA1 : 32'hB1);
    end

    // Drain: nothing valid, held beat unloads, sel keeps B.
    applyStimulus(1'b0, 8'hA1, 1'b0, 8'hB1, 1'b1);
    nextCycle();
    checkOutput("drain_out_valid", 32'(outValid), 32'd0);
    checkOutput("drain_sel",       32'(sel),      32'd1);
    checkOutput("drain_out_data",  32'(outData),  32'hB1);

    // Single source A.
    applyStimulus(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("single_a_ready", 32'(aReady), 32'd1);
    checkOutput("single_b_ready", 32'(bReady), 32'd0);
    nextCycle();
    checkOutput("single_out_valid", 32'(outValid), 32'd1);
    checkOutput("single_out_data",  32'(outData),  32'h01);
    checkOutput("single_sel",       32'(sel),      32'd0);

    // Backpressure for three cycles, then resume: B wins since A went last.
    applyStimulus(1'b1, 8'h02, 1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_a_ready", 32'(aReady), 32'd0);
      checkOutput("bp_b_ready", 32'(bReady), 32'd0);
      nextCycle();
      checkOutput("bp_out_valid", 32'(outValid), 32'd1);
      checkOutput("bp_out_data",  32'(outData),  32'h01);
      checkOutput("bp_sel",       32'(sel),      32'd0);
    end
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("resume_b_ready", 32'(bReady), 32'd1);
    nextCycle();
    checkOutput("resume_out_data", 32'(outData), 32'h03);
    checkOutput("resume_sel",      32'(sel),     32'd1);
    bValid = 1'b0;
    nextCycle();
    checkOutput("resume2_out_data", 32'(outData), 32'h02);
    checkOutput("resume2_sel",      32'(sel),     32'd0);

    // Asynchronous reset with a beat held; first tie afterwards goes to A.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("async_rst_out_data",  32'(outData),  32'd0);
    checkOutput("async_rst_sel",       32'(sel),      32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h05, 1'b1, 8'h06, 1'b1);
    nextCycle();
    checkOutput("post_rst_tie_sel",  32'(sel),     32'd0);
    checkOutput("post_rst_tie_data", 32'(outData), 32'h05);
    applyStimulus(1'b0, 8'h05, 1'b1, 8'h06, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    nextCycle();

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: A sends three beats with last on the third while B waits.
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bLast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h11 + i), 1'b1, 8'h22, 1'b1);
      aLast = (i == 2);
      @(negedge clk);
      checkOutput("lock_b_ready", 32'(bReady), 32'd0);
      nextCycle();
      checkOutput("lock_sel",      32'(sel),      32'd0);
      checkOutput("lock_out_data", 32'(outData),  32'(8'h11 + i));
      checkOutput("lock_out_last", 32'(outLast),  32'(i == 2));
    end
    aValid = 1'b0;
    nextCycle();
    checkOutput("lock_release_sel",  32'(sel),     32'd1);
    checkOutput("lock_release_data", 32'(outData), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    nextCycle();
`endif

    // Random traffic obeying the hold-until-ready source rule.
    accA = 1'b1;
    accB = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!aValid || accA) begin
        aValid = ($urandom_range(0, 3) != 0);
        aData  = DATA_W'($urandom);
`ifdef MUX_ARB_LOCK_EN
        aLast  = ($urandom_range(0, 2) == 0);
`endif
      end
      if (!bValid || accB) begin
        bValid = ($urandom_range(0, 3) != 0);
        bData  = DATA_W'($urandom);
`ifdef MUX_ARB_LOCK_EN
        bLast  = ($urandom_range(0, 2) == 0);
`endif
      end
      outReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accA = aValid && aReady;
      accB = bValid && bReady;
      nextCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
